snap_phase_addr_gen: RTL and testbench

Capture controller for the per-channel phase snapshot. It sits directly upstream of the software-readable snapshot-address register and drives that register's 32-bit user-data input. On an arm request it waits for a frame sync, then writes the phase of one selected channel into a snapshot BRAM on every frame. It publishes the current write address and busy/done status, so the PowerPC can poll capture progress.

---
 rtl/snap_phase_addr_gen_if.sv | 28 ++
 rtl/snap_phase_addr_gen.sv | 102 ++++++++++
 tb/tb_snap_phase_addr_gen.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/snap_phase_addr_gen_if.sv
// Signal bundle between the channelizer/software control side and the phase snapshot
// capture controller, including the BRAM write port and the status word.
interface snap_phase_addr_gen_if #(
    parameter int ADDR_W = 9,
    parameter int CH_W   = 9,
    parameter int PH_W   = 16
);
    logic                     arm;
    logic [CH_W-1:0]          ch_sel;
    logic                     sync_in;
    logic [CH_W-1:0]          ch_idx;
    logic signed [PH_W-1:0]   phase_in;
    logic                     phase_valid;
    logic                     bram_we;
    logic [ADDR_W-1:0]        bram_addr;
    logic [31:0]              bram_din;
    logic [31:0]              addr_out;

    modport master (
        output arm, ch_sel, sync_in, ch_idx, phase_in, phase_valid,
        input  bram_we, bram_addr, bram_din, addr_out
    );

    modport slave (
        input  arm, ch_sel, sync_in, ch_idx, phase_in, phase_valid,
        output bram_we, bram_addr, bram_din, addr_out
    );
endinterface

// File: rtl/snap_phase_addr_gen.sv
// Phase snapshot capture controller: on arm, waits for frame sync and then writes one
// selected channel's phase (tagged with a frame count) into a snapshot BRAM until full.
module snap_phase_addr_gen #(
    parameter int ADDR_W = 9,
    parameter int CH_W   = 9,
    parameter int PH_W   = 16
) (
    input  logic                  user_clk,
    input  logic                  user_rst,
    snap_phase_addr_gen_if.slave  cap
);

    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

    state_t              state;
    logic                arm_d;
    logic [CH_W-1:0]     sel_q;
    logic [ADDR_W-1:0]   wr_cnt;
    logic [15:0]         frame_cnt;

    logic                arm_edge;
    logic                match;
    logic                take;
    logic [15:0]         frame_nxt;

    function automatic logic [15:0] sext16(input logic signed [PH_W-1:0] p);
        return 16'(p);
    endfunction

    function automatic logic [31:0] status_word(input logic done, input logic busy,
                                                input logic [ADDR_W-1:0] addr);
        logic [31:0] w;
        w              = '0;
        w[31]          = done;
        w[30]          = busy;
        w[ADDR_W-1:0]  = addr;
        return w;
    endfunction

    // A sync coinciding with a matching sample in CAPTURE bumps the frame count first,
    // so the sample is tagged with the new frame number.
    always_comb begin
        arm_edge  = cap.arm & ~arm_d;
        match     = cap.phase_valid && (cap.ch_idx == sel_q);
        frame_nxt = (state == CAPTURE && cap.sync_in) ? frame_cnt + 16'd1 : frame_cnt;
        take      = match && ((state == CAPTURE) || (state == ARMED && cap.sync_in));
    end

    always_ff @(posedge user_clk or posedge user_rst) begin
        if (user_rst) begin
            state         <= IDLE;
            arm_d         <= 1'b0;
            sel_q         <= '0;
            wr_cnt        <= '0;
            frame_cnt     <= '0;
            cap.bram_we   <= 1'b0;
            cap.bram_addr <= '0;
            cap.bram_din  <= '0;
            cap.addr_out  <= '0;
        end else begin
            arm_d       <= cap.arm;
            cap.bram_we <= 1'b0;

            case (state)
                IDLE, DONE: begin
                    if (arm_edge) begin
                        sel_q        <= cap.ch_sel;
                        wr_cnt       <= '0;
                        frame_cnt    <= '0;
                        cap.addr_out <= status_word(1'b0, 1'b1, '0);
                        state        <= ARMED;
                    end
                end
                ARMED: begin
                    if (cap.sync_in) state <= CAPTURE;
                end
                CAPTURE: begin
                    frame_cnt <= frame_nxt;
                end
                default: state <= IDLE;
            endcase

            // Write stage: BRAM port and status address field update together.
            if (take) begin
                cap.bram_we   <= 1'b1;
                cap.bram_addr <= wr_cnt;
                cap.bram_din  <= {frame_nxt, sext16(cap.phase_in)};
                if (wr_cnt == LAST_ADDR) begin
                    cap.addr_out <= status_word(1'b1, 1'b0, wr_cnt);
                    state        <= DONE;
                end else begin
                    cap.addr_out <= status_word(1'b0, 1'b1, wr_cnt);
                    wr_cnt       <= wr_cnt + ADDR_ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_snap_phase_addr_gen.sv
// Bench for snap_phase_addr_gen: single-cycle vector table plus scoreboarded capture runs
// (async reset mid-capture, full capture, ignored re-arm, re-arm from done).
module tb_snap_phase_addr_gen;

    localparam int ADDR_W = 9;
    localparam int CH_W   = 9;
    localparam int PH_W   = 12;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    snap_phase_addr_gen_if #(.ADDR_W(ADDR_W), .CH_W(CH_W), .PH_W(PH_W)) bus ();

    snap_phase_addr_gen #(.ADDR_W(ADDR_W), .CH_W(CH_W), .PH_W(PH_W)) dut (
        .user_clk (clk),
        .user_rst (rst),
        .cap      (bus)
    );

    typedef struct {
        logic        arm;
        logic [8:0]  sel;
        logic        sync;
        logic [8:0]  ch;
        logic [11:0] ph;
        logic        vld;
        logic        exp_we;
        logic [8:0]  exp_addr;
        logic [31:0] exp_din;
        logic [31:0] exp_stat;
    } vec_t;

    typedef struct {
        logic [8:0]  addr;
        logic [31:0] din;
        logic [31:0] stat;
    } exp_t;

    vec_t tbl [10];
    exp_t q [$];

    int   n_chk  = 0;
    int   n_pass = 0;
    logic sb_on  = 1'b0;

    // Reference capture model state
    int          ms;
    logic        m_arm_d;
    logic [8:0]  m_sel;
    logic [8:0]  m_wr;
    logic [15:0] m_fc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    endtask

    function automatic logic [15:0] sx(input logic [11:0] p);
        return {{4{p[11]}}, p};
    endfunction

    task automatic model_reset();
        ms      = 0;
        m_arm_d = 1'b0;
        m_sel   = '0;
        m_wr    = '0;
        m_fc    = '0;
    endtask

    task automatic drive_cycle(input int a, input int sel, input int s, input int ch,
                               input int ph, input int v);
        logic edge_v;
        logic hit;
        logic take;
        exp_t e;
        @(negedge clk);
        bus.arm         = a[0];
        bus.ch_sel      = sel[8:0];
        bus.sync_in     = s[0];
        bus.ch_idx      = ch[8:0];
        bus.phase_in    = ph[11:0];
        bus.phase_valid = v[0];

        edge_v  = a[0] && !m_arm_d;
        m_arm_d = a[0];
        hit     = v[0] && (ch[8:0] == m_sel);
        take    = 1'b0;
        case (ms)
            0, 3: if (edge_v) begin
                m_sel = sel[8:0]; m_wr = '0; m_fc = '0; ms = 1;
            end
            1: if (s[0]) begin
                ms = 2; take = v[0] && (ch[8:0] == m_sel);
            end
            2: begin
                if (s[0]) m_fc = m_fc + 16'd1;
                take = hit;
            end
            default: ;
        endcase
        if (take) begin
            e.addr = m_wr;
            e.din  = {m_fc, sx(ph[11:0])};
            if (m_wr == 9'd511) begin
                e.stat = 32'h8000_0000 | {23'd0, m_wr};
                ms = 3;
            end else begin
                e.stat = 32'h4000_0000 | {23'd0, m_wr};
                m_wr = m_wr + 9'd1;
            end
            q.push_back(e);
        end
    endtask

    task automatic short_frame(input int a, input int sel);
        drive_cycle(a, sel, 1, 37, $urandom_range(0, 4095), 1);
        drive_cycle(a, sel, 0, 37, $urandom_range(0, 4095), 1);
        drive_cycle(a, sel, 0, 38, $urandom_range(0, 4095), 1);
        drive_cycle(a, sel, 0, 37, $urandom_range(0, 4095), 0);
    endtask

    always @(negedge clk) begin
        if (sb_on && !rst && bus.bram_we) begin
            if (q.size() == 0) begin
                chk("no_write", {31'd0, bus.bram_we}, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("wr_addr", {23'd0, bus.bram_addr}, {23'd0, e.addr});
                chk("wr_din", bus.bram_din, e.din);
                chk("wr_status", bus.addr_out, e.stat);
            end
        end
    end

    initial begin
        int guard;
        logic rearm_done;

        tbl[0] = '{1'b0, 9'd0, 1'b0, 9'd0, 12'h000, 1'b0, 1'b0, 9'd0, 32'h0, 32'h0000_0000};
        tbl[1] = '{1'b1, 9'd5, 1'b0, 9'd5, 12'h111, 1'b1, 1'b0, 9'd0, 32'h0, 32'h4000_0000};
        tbl[2] = '{1'b1, 9'd9, 1'b0, 9'd5, 12'h222, 1'b1, 1'b0, 9'd0, 32'h0, 32'h4000_0000};
        tbl[3] = '{1'b1, 9'd9, 1'b1, 9'd5, 12'hFFD, 1'b1, 1'b1, 9'd0, 32'h0000_FFFD, 32'h4000_0000};
        tbl[4] = '{1'b1, 9'd9, 1'b0, 9'd9, 12'h007, 1'b1, 1'b0, 9'd0, 32'h0, 32'h4000_0000};
        tbl[5] = '{1'b1, 9'd9, 1'b0, 9'd5, 12'h123, 1'b1, 1'b1, 9'd1, 32'h0000_0123, 32'h4000_0001};
        tbl[6] = '{1'b1, 9'd9, 1'b1, 9'd0, 12'h000, 1'b0, 1'b0, 9'd0, 32'h0, 32'h4000_0001};
        tbl[7] = '{1'b0, 9'd9, 1'b1, 9'd5, 12'h800, 1'b1, 1'b1, 9'd2, 32'h0002_F800, 32'h4000_0002};
        tbl[8] = '{1'b1, 9'd9, 1'b0, 9'd5, 12'h555, 1'b1, 1'b1, 9'd3, 32'h0002_0555, 32'h4000_0003};
        tbl[9] = '{1'b1, 9'd9, 1'b0, 9'd9, 12'h7FF, 1'b1, 1'b0, 9'd0, 32'h0, 32'h4000_0003};

        rst = 1'b1;
        bus.arm = 1'b0; bus.ch_sel = '0; bus.sync_in = 1'b0;
        bus.ch_idx = '0; bus.phase_in = '0; bus.phase_valid = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_we", {31'd0, bus.bram_we}, 32'd0);
        chk("rst_addr", {23'd0, bus.bram_addr}, 32'd0);
        chk("rst_din", bus.bram_din, 32'd0);
        chk("rst_status", bus.addr_out, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Single-cycle vectors: outputs checked one clock after each row is applied
        for (int i = 0; i < 10; i++) begin
            drive_cycle(tbl[i].arm, tbl[i].sel, tbl[i].sync, tbl[i].ch, tbl[i].ph, tbl[i].vld);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_we", i), {31'd0, bus.bram_we}, {31'd0, tbl[i].exp_we});
            if (tbl[i].exp_we) begin
                chk($sformatf("vec%0d_addr", i), {23'd0, bus.bram_addr}, {23'd0, tbl[i].exp_addr});
                chk($sformatf("vec%0d_din", i), bus.bram_din, tbl[i].exp_din);
            end
            chk($sformatf("vec%0d_status", i), bus.addr_out, tbl[i].exp_stat);
        end
        drive_cycle(0, 0, 0, 0, 0, 0);
        q.delete();

        // Async reset after 100 writes of a capture
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        sb_on = 1'b1;
        guard = 0;
        while (m_wr < 9'd100 && guard < 2000) begin
            drive_cycle(1, 37, (guard % 4 == 0) ? 1 : 0, 37, $urandom_range(0, 4095), 1);
            guard++;
        end
        if (guard >= 2000) chk("timeout_100", 32'd1, 32'd0);
        @(posedge clk);
        #2;
        chk("pre_rst_we", {31'd0, bus.bram_we}, 32'd1);
        rst = 1'b1;
        bus.arm = 1'b0; bus.sync_in = 1'b0; bus.phase_valid = 1'b0;
        #1;
        chk("async_rst_we", {31'd0, bus.bram_we}, 32'd0);
        chk("async_rst_status", bus.addr_out, 32'd0);
        q.delete();
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 20; i++)
            drive_cycle(0, 37, (i % 4 == 0) ? 1 : 0, 37, $urandom_range(0, 4095), 1);
        chk("post_rst_status", bus.addr_out, 32'd0);

        // Full capture: arm, pre-sync samples dropped, three full channel frames
        drive_cycle(1, 37, 0, 37, $urandom_range(0, 4095), 1);
        @(posedge clk);
        #1;
        chk("armed_status", bus.addr_out, 32'h4000_0000);
        drive_cycle(1, 37, 0, 37, $urandom_range(0, 4095), 1);
        drive_cycle(1, 37, 0, 37, $urandom_range(0, 4095), 1);
        for (int f = 0; f < 3; f++)
            for (int c = 0; c < 512; c++)
                drive_cycle(1, 37, (c == 0) ? 1 : 0, c, $urandom_range(0, 4095), 1);

        rearm_done = 1'b0;
        guard = 0;
        while (ms != 3 && guard < 1000) begin
            if (!rearm_done && m_wr >= 9'd200) begin
                drive_cycle(0, 99, 0, 38, 0, 1);
                drive_cycle(1, 99, 0, 37, $urandom_range(0, 4095), 1);
                rearm_done = 1'b1;
            end
            if (rearm_done) short_frame(1, 99);
            else short_frame(1, 37);
            guard++;
        end
        if (guard >= 1000) chk("timeout_full", 32'd1, 32'd0);
        for (int i = 0; i < 10; i++) short_frame(1, 99);
        chk("done_status", bus.addr_out, 32'h8000_01FF);
        chk("sb_drain_full", q.size(), 32'd0);

        // Re-arm from DONE restarts at address 0, frame 0
        drive_cycle(0, 37, 0, 0, 0, 0);
        drive_cycle(1, 37, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        chk("rearm_status", bus.addr_out, 32'h4000_0000);
        for (int i = 0; i < 5; i++) short_frame(1, 37);
        drive_cycle(1, 37, 0, 0, 0, 0);
        drive_cycle(1, 37, 0, 0, 0, 0);
        chk("rearm_status_end", bus.addr_out, 32'h4000_0009);
        chk("sb_drain_rearm", q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
